// File: rtl/demux2_out_buffer_pkg.sv
// Shared constants for the 1-to-2 demux and its downstream output buffer.
package demux2_out_buffer_pkg;
  localparam int DATA_W        = 16;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_e;
endpackage

// File: rtl/demux2_out_buffer_fifo.sv
// Per-channel synchronous FIFO with first-word fall-through head output.
module sync_fifo_ch #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_reg;
  logic [AW-1:0] rptr_reg;
  logic [CW-1:0] count_reg;
  logic          push_en;
  logic          pop_en;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign count   = count_reg;
  // Head is read combinationally so the word is visible the cycle after its push.
  assign head    = empty ? '0 : mem[rptr_reg];

  always_ff @(posedge clk) begin
    if (push_en && !rst) begin
      mem[wptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_en) wptr_reg <= wptr_reg + 1'b1;
      if (pop_en)  rptr_reg <= rptr_reg + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/demux2_out_buffer.sv
// Routes the active demux output into one of two FIFOs and flags demux misuse.
module demux2_out_buffer
  import demux2_out_buffer_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_select,
  input  logic [W-1:0]           in_data_0,
  input  logic [W-1:0]           in_data_1,
  output logic                   in_ready,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [W-1:0]           out0_data,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [W-1:0]           out1_data,
  output logic [$clog2(DEPTH):0] count0,
  output logic [$clog2(DEPTH):0] count1,
  output logic                   sel_err
);
  logic full0, full1, empty0, empty1;
  logic push0, push1;
  logic sel_err_reg;
  logic unsel_nonzero;

  assign in_ready = (in_select == CH1) ? !full1 : !full0;
  assign push0    = in_valid && in_ready && (in_select == CH0);
  assign push1    = in_valid && in_ready && (in_select == CH1);

  assign unsel_nonzero = (in_select == CH1) ? (in_data_0 != '0) : (in_data_1 != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_reg <= 1'b0;
    end else if (in_valid && unsel_nonzero) begin
      sel_err_reg <= 1'b1;
    end
  end
  assign sel_err = sel_err_reg;

  sync_fifo_ch #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (in_data_0),
    .pop       (out0_ready),
    .full      (full0),
    .empty     (empty0),
    .head      (out0_data),
    .count     (count0)
  );

  sync_fifo_ch #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in_data_1),
    .pop       (out1_ready),
    .full      (full1),
    .empty     (empty1),
    .head      (out1_data),
    .count     (count1)
  );

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
endmodule
